// File: rtl/ps2_mouse_packet_ctrl_pkg.sv
// Shared constants for the PS/2 mouse packet controller: command/response
// bytes, FSM state encoding and the init-sequence length.
// Build option: PS2_MOUSE_WHEEL_EN selects the IntelliMouse unlock sequence
// and 4-byte packets.
package ps2_mouse_pkg;

  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_SETRATE = 8'hF3;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_ERR     = 8'hFC;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND_CMD = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_RX_B0    = 3'd3;
  localparam logic [2:0] ST_RX_B1    = 3'd4;
  localparam logic [2:0] ST_RX_B2    = 3'd5;
  localparam logic [2:0] ST_RX_B3    = 3'd6;

`ifdef PS2_MOUSE_WHEEL_EN
  // Sample-rate arguments of the 200/100/80 unlock knock
  localparam logic [7:0] RATE_200   = 8'hC8;
  localparam logic [7:0] RATE_100   = 8'h64;
  localparam logic [7:0] RATE_80    = 8'h50;
  localparam int         SEQ_LEN    = 7;
  localparam logic [2:0] ST_RX_LAST = ST_RX_B3;
`else
  localparam int         SEQ_LEN    = 1;
  localparam logic [2:0] ST_RX_LAST = ST_RX_B2;
`endif

  localparam logic [2:0] SEQ_LAST = 3'(SEQ_LEN - 1);

endpackage

// File: rtl/ps2_mouse_packet_ctrl_if.sv
// Byte-level link between the packet controller (master) and the PS/2
// TX/RX engines (slave).
interface ps2_mouse_packet_ctrl_if;

  logic       tx_trig;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_en;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output tx_trig, tx_data, rx_en,
    input  tx_done, rx_valid, rx_data
  );

  modport slave (
    input  tx_trig, tx_data, rx_en,
    output tx_done, rx_valid, rx_data
  );

endinterface

// File: rtl/ps2_mouse_packet_ctrl_pos_accum.sv
// Saturating absolute-position accumulator. Adds (or, with SUB=1, subtracts)
// a 9-bit signed delta and pins the result to 0..MAX; the arithmetic is done
// two bits wider than the register so it can never wrap.
module ps2_pos_accum #(
  parameter int W   = 10,
  parameter int MAX = 639,
  parameter bit SUB = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [8:0]   delta,
  output logic [W-1:0] pos
);

  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

  logic signed [SW-1:0] d_ext;
  logic signed [SW-1:0] cur;
  logic signed [SW-1:0] sum;
  logic [W-1:0]         pos_n;

  // Widened add/subtract followed by clamp to the legal range
  always_comb begin
    d_ext = {{(SW-9){delta[8]}}, delta};
    cur   = {2'b00, pos};
    sum   = SUB ? (cur - d_ext) : (cur + d_ext);
    if (sum[SW-1])
      pos_n = '0;
    else if (sum > MAX_S)
      pos_n = W'(MAX);
    else
      pos_n = sum[W-1:0];
  end

  // Position register, starts at mid-range
  always_ff @(posedge clk) begin
    if (rst)
      pos <= W'(MAX / 2);
    else if (en)
      pos <= pos_n;
  end

endmodule

// File: rtl/ps2_mouse_packet_ctrl.sv
// PS/2 mouse host controller: sends the enable (and optionally the wheel
// unlock) command sequence, checks each ACK with retry/timeout, then
// assembles streamed movement packets into buttons, deltas and a saturating
// absolute position.
// Build option: PS2_MOUSE_WHEEL_EN adds the unlock sequence, RX_B3 and dz.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for start; stays here forever once err_init set
// ST_SEND_CMD | tx_trig held, current init command on tx_data
// ST_WAIT_ACK | expecting FA; other byte or timeout costs one retry
// ST_RX_B0    | waiting for a status byte with bit3 set (resync)
// ST_RX_B1    | waiting for the X byte
// ST_RX_B2    | waiting for the Y byte
// ST_RX_B3    | waiting for the Z byte (wheel build only)
module ps2_mouse_packet_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int POS_W     = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int ACK_TO    = 65535,
  parameter int MAX_RETRY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  ps2_mouse_packet_ctrl_if.master bus,
  output logic                    pkt_valid,
  output logic [2:0]              buttons,
  output logic [8:0]              dx,
  output logic [8:0]              dy,
`ifdef PS2_MOUSE_WHEEL_EN
  output logic [3:0]              dz,
`endif
  output logic [POS_W-1:0]        pos_x,
  output logic [POS_W-1:0]        pos_y,
  output logic                    streaming,
  output logic                    err_init,
  output logic                    err_sync
);

  localparam int TMR_W = $clog2(ACK_TO + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TO - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  logic [2:0]       state;
  logic [2:0]       cmd_idx;
  logic [RTY_W-1:0] retry;
  logic [TMR_W-1:0] tmr;

  // Status-byte fields kept until the packet completes
  logic [2:0]       b0_btn;
  logic             b0_xs;
  logic             b0_ys;
  logic             b0_ovf;
  logic [7:0]       b1_q;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0]       b2_q;
`endif

  logic [7:0]       rom_cmd;
  logic             ack_ok;
  logic             wait_fail;
  logic             pkt_done;
  logic             pkt_good;
  logic [8:0]       dx_n;
  logic [8:0]       dy_n;

  // Init command ROM indexed by the sequence position
  always_comb begin
`ifdef PS2_MOUSE_WHEEL_EN
    case (cmd_idx)
      3'd0:    rom_cmd = CMD_SETRATE;
      3'd1:    rom_cmd = RATE_200;
      3'd2:    rom_cmd = CMD_SETRATE;
      3'd3:    rom_cmd = RATE_100;
      3'd4:    rom_cmd = CMD_SETRATE;
      3'd5:    rom_cmd = RATE_80;
      default: rom_cmd = CMD_ENABLE;
    endcase
`else
    rom_cmd = CMD_ENABLE;
`endif
  end

  // Handshake decode and the deltas of the packet being completed
  always_comb begin
    ack_ok    = (state == ST_WAIT_ACK) && bus.rx_valid && (bus.rx_data == RSP_ACK);
    wait_fail = (state == ST_WAIT_ACK) &&
                ((bus.rx_valid && (bus.rx_data != RSP_ACK)) ||
                 (!bus.rx_valid && (tmr == '0)));
    pkt_done  = (state == ST_RX_LAST) && bus.rx_valid;
    pkt_good  = pkt_done && !b0_ovf;
    dx_n      = {b0_xs, b1_q};
`ifdef PS2_MOUSE_WHEEL_EN
    dy_n      = {b0_ys, b2_q};
`else
    dy_n      = {b0_ys, bus.rx_data};
`endif
  end

  // tx_trig/rx_en follow the state directly so a reset drops them at once
  assign bus.tx_trig = (state == ST_SEND_CMD);
  assign bus.tx_data = (state == ST_SEND_CMD) ? rom_cmd : 8'h00;
  assign bus.rx_en   = (state == ST_WAIT_ACK) || (state == ST_RX_B0) ||
                       (state == ST_RX_B1) || (state == ST_RX_B2) ||
                       (state == ST_RX_B3);
  assign streaming   = (state == ST_RX_B0) || (state == ST_RX_B1) ||
                       (state == ST_RX_B2) || (state == ST_RX_B3);

  // Sequencing FSM, ACK timer, retry counter and packet capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_idx   <= '0;
      retry     <= '0;
      tmr       <= '0;
      err_init  <= 1'b0;
      err_sync  <= 1'b0;
      pkt_valid <= 1'b0;
      buttons   <= '0;
      dx        <= '0;
      dy        <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
      dz        <= '0;
      b2_q      <= '0;
`endif
      b0_btn    <= '0;
      b0_xs     <= 1'b0;
      b0_ys     <= 1'b0;
      b0_ovf    <= 1'b0;
      b1_q      <= '0;
    end else begin
      pkt_valid <= 1'b0;
      err_sync  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !err_init) begin
            state   <= ST_SEND_CMD;
            cmd_idx <= '0;
            retry   <= '0;
          end
        end
        ST_SEND_CMD: begin
          if (bus.tx_done) begin
            state <= ST_WAIT_ACK;
            tmr   <= TMR_LOAD;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_ok) begin
            retry <= '0;
            if (cmd_idx == SEQ_LAST) begin
              state <= ST_RX_B0;
            end else begin
              cmd_idx <= cmd_idx + 3'd1;
              state   <= ST_SEND_CMD;
            end
          end else if (wait_fail) begin
            if (retry == RTY_MAX) begin
              err_init <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              retry <= retry + 1'b1;
              state <= ST_SEND_CMD;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_RX_B0: begin
          if (bus.rx_valid) begin
            if (bus.rx_data[3]) begin
              b0_btn <= bus.rx_data[2:0];
              b0_xs  <= bus.rx_data[4];
              b0_ys  <= bus.rx_data[5];
              b0_ovf <= bus.rx_data[6] | bus.rx_data[7];
              state  <= ST_RX_B1;
            end else begin
              err_sync <= 1'b1;
            end
          end
        end
        ST_RX_B1: begin
          if (bus.rx_valid) begin
            b1_q  <= bus.rx_data;
            state <= ST_RX_B2;
          end
        end
`ifdef PS2_MOUSE_WHEEL_EN
        ST_RX_B2: begin
          if (bus.rx_valid) begin
            b2_q  <= bus.rx_data;
            state <= ST_RX_B3;
          end
        end
        ST_RX_B3: begin
          if (bus.rx_valid)
            state <= ST_RX_B0;
        end
`else
        ST_RX_B2: begin
          if (bus.rx_valid)
            state <= ST_RX_B0;
        end
`endif
        default: state <= ST_IDLE;
      endcase

      if (pkt_done) begin
        if (b0_ovf) begin
          err_sync <= 1'b1;
        end else begin
          pkt_valid <= 1'b1;
          buttons   <= b0_btn;
          dx        <= dx_n;
          dy        <= dy_n;
`ifdef PS2_MOUSE_WHEEL_EN
          dz        <= bus.rx_data[3:0];
`endif
        end
      end
    end
  end

  ps2_pos_accum #(.W(POS_W), .MAX(X_MAX), .SUB(1'b0)) u_acc_x (
    .clk   (clk),
    .rst   (rst),
    .en    (pkt_good),
    .delta (dx_n),
    .pos   (pos_x)
  );

  // Screen Y grows downward while mouse +dy means up
  ps2_pos_accum #(.W(POS_W), .MAX(Y_MAX), .SUB(1'b1)) u_acc_y (
    .clk   (clk),
    .rst   (rst),
    .en    (pkt_good),
    .delta (dy_n),
    .pos   (pos_y)
  );

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Directed bench for ps2_mouse_packet_ctrl. ACK_TO is shortened so the
// timeout retry path can be exercised quickly.
module tb_ps2_mouse_packet_ctrl;
  import ps2_mouse_pkg::*;

  localparam int ACK_TO_TB = 40;
`ifdef PS2_MOUSE_WHEEL_EN
  localparam int         SEQ_N     = 7;
  localparam logic [7:0] FIRST_CMD = 8'hF3;
`else
  localparam int         SEQ_N     = 1;
  localparam logic [7:0] FIRST_CMD = 8'hF4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [3:0] dz;
`endif
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       streaming;
  logic       err_init;
  logic       err_sync;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_mouse_packet_ctrl_if bus ();

  ps2_mouse_packet_ctrl #(.ACK_TO(ACK_TO_TB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .pkt_valid (pkt_valid),
    .buttons   (buttons),
    .dx        (dx),
    .dy        (dy),
`ifdef PS2_MOUSE_WHEEL_EN
    .dz        (dz),
`endif
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .streaming (streaming),
    .err_init  (err_init),
    .err_sync  (err_sync)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_cmd(input int k);
`ifdef PS2_MOUSE_WHEEL_EN
    case (k)
      0, 2, 4: return 8'hF3;
      1:       return 8'hC8;
      3:       return 8'h64;
      5:       return 8'h50;
      default: return 8'hF4;
    endcase
`else
    return (k == 0) ? 8'hF4 : 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
`ifdef PS2_MOUSE_WHEEL_EN
    send_byte(8'h00);
`endif
  endtask

  // Plays the TX engine: waits (bounded) for tx_trig, captures tx_data, pulses tx_done
  task automatic serve_cmd(output bit seen, output logic [7:0] d);
    seen = 1'b0;
    d    = 8'h00;
    for (int i = 0; i < 30; i++) begin
      if (bus.tx_trig) begin
        seen = 1'b1;
        d    = bus.tx_data;
        break;
      end
      tick();
    end
    if (seen) begin
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] zeros;
    start = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    zeros = {5'd0, pkt_valid, buttons, dx, dy, streaming, err_init, err_sync,
             bus.tx_trig, bus.rx_en, 1'b0};
    n_checks++;
    if (zeros !== 32'd0 || bus.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got flags %h tx_data %h, expected 0/00", zeros, bus.tx_data);
    end
    n_checks++;
    if (pos_x !== 10'd319) begin
      n_fail++;
      $display("FAIL reset_pos_x: got %0d expected 319", pos_x);
    end
    n_checks++;
    if (pos_y !== 10'd239) begin
      n_fail++;
      $display("FAIL reset_pos_y: got %0d expected 239", pos_y);
    end
  endtask

  task automatic test_init();
    bit         seen;
    logic [7:0] d;
    start = 1'b1;
    for (int k = 0; k < SEQ_N; k++) begin
      serve_cmd(seen, d);
      n_checks++;
      if (!seen || d !== exp_cmd(k)) begin
        n_fail++;
        $display("FAIL init_cmd%0d: seen %0d got %h expected %h", k, seen, d, exp_cmd(k));
      end
      n_checks++;
      if (bus.rx_en !== 1'b1 || streaming !== 1'b0) begin
        n_fail++;
        $display("FAIL init_wait_ack%0d: rx_en %b streaming %b expected 1/0", k, bus.rx_en, streaming);
      end
      send_byte(RSP_ACK);
    end
    start = 1'b0;
    n_checks++;
    if (streaming !== 1'b1 || err_init !== 1'b0) begin
      n_fail++;
      $display("FAIL init_streaming: streaming %b err_init %b expected 1/0", streaming, err_init);
    end
  endtask

  task automatic test_packet();
    send_byte(8'h28);
    send_byte(8'h05);
    n_checks++;
    if (pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_early: pkt_valid %b expected 0", pkt_valid);
    end
    send_byte(8'hFD);
`ifdef PS2_MOUSE_WHEEL_EN
    send_byte(8'h00);
`endif
    n_checks++;
    if (pkt_valid !== 1'b1 || buttons !== 3'b000 || dx !== 9'h005 || dy !== 9'h1FD) begin
      n_fail++;
      $display("FAIL pkt_decode: valid %b btn %b dx %h dy %h expected 1 000 005 1fd",
               pkt_valid, buttons, dx, dy);
    end
    n_checks++;
    if (pos_x !== 10'd324 || pos_y !== 10'd242) begin
      n_fail++;
      $display("FAIL pkt_pos: got %0d,%0d expected 324,242", pos_x, pos_y);
    end
    tick();
    n_checks++;
    if (pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_pulse_width: pkt_valid %b expected 0", pkt_valid);
    end
  endtask

  task automatic test_resync();
    send_byte(8'h05);
    n_checks++;
    if (err_sync !== 1'b1 || streaming !== 1'b1 || pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_pulse: err_sync %b streaming %b pkt_valid %b expected 1 1 0",
               err_sync, streaming, pkt_valid);
    end
    send_pkt(8'h09, 8'h7F, 8'h00);
    n_checks++;
    if (pkt_valid !== 1'b1 || err_sync !== 1'b0 || buttons !== 3'b001 || dx !== 9'h07F) begin
      n_fail++;
      $display("FAIL resync_pkt: valid %b err_sync %b btn %b dx %h expected 1 0 001 07f",
               pkt_valid, err_sync, buttons, dx);
    end
    n_checks++;
    if (pos_x !== 10'd451 || pos_y !== 10'd242) begin
      n_fail++;
      $display("FAIL resync_pos: got %0d,%0d expected 451,242", pos_x, pos_y);
    end
  endtask

  task automatic test_clamp_x_low();
    int exp_x = 451;
    for (int i = 0; i < 20; i++) begin
      send_pkt(8'h18, 8'h00, 8'h00);
      exp_x = (exp_x >= 256) ? exp_x - 256 : 0;
      n_checks++;
      if (pos_x !== 10'(exp_x) || dx !== 9'h100) begin
        n_fail++;
        $display("FAIL clamp_x_low%0d: pos_x %0d dx %h expected %0d 100", i, pos_x, dx, exp_x);
      end
    end
  endtask

  task automatic test_clamp_edges();
    send_pkt(8'h08, 8'h00, 8'hFD);
    n_checks++;
    if (pos_y !== 10'd0) begin
      n_fail++;
      $display("FAIL clamp_y_low: got %0d expected 0", pos_y);
    end
    send_pkt(8'h28, 8'h00, 8'h01);
    n_checks++;
    if (pos_y !== 10'd255) begin
      n_fail++;
      $display("FAIL y_up_255: got %0d expected 255", pos_y);
    end
    send_pkt(8'h28, 8'h00, 8'h01);
    n_checks++;
    if (pos_y !== 10'd479) begin
      n_fail++;
      $display("FAIL clamp_y_high: got %0d expected 479", pos_y);
    end
    send_pkt(8'h08, 8'hFF, 8'h00);
    send_pkt(8'h08, 8'hFF, 8'h00);
    n_checks++;
    if (pos_x !== 10'd510) begin
      n_fail++;
      $display("FAIL x_right_510: got %0d expected 510", pos_x);
    end
    send_pkt(8'h08, 8'hFF, 8'h00);
    n_checks++;
    if (pos_x !== 10'd639) begin
      n_fail++;
      $display("FAIL clamp_x_high: got %0d expected 639", pos_x);
    end
  endtask

  task automatic test_overflow();
    send_pkt(8'h48, 8'h10, 8'h10);
    n_checks++;
    if (err_sync !== 1'b1 || pkt_valid !== 1'b0 || pos_x !== 10'd639 || pos_y !== 10'd479) begin
      n_fail++;
      $display("FAIL overflow_x: err_sync %b valid %b pos %0d,%0d expected 1 0 639,479",
               err_sync, pkt_valid, pos_x, pos_y);
    end
    send_pkt(8'h98, 8'h80, 8'h10);
    n_checks++;
    if (err_sync !== 1'b1 || pkt_valid !== 1'b0 || pos_x !== 10'd639 || pos_y !== 10'd479) begin
      n_fail++;
      $display("FAIL overflow_y: err_sync %b valid %b pos %0d,%0d expected 1 0 639,479",
               err_sync, pkt_valid, pos_x, pos_y);
    end
  endtask

  task automatic test_back_to_back();
    send_pkt(8'h0A, 8'h00, 8'h00);
    n_checks++;
    if (pkt_valid !== 1'b1 || buttons !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_first: valid %b btn %b expected 1 010", pkt_valid, buttons);
    end
    send_pkt(8'h0C, 8'h00, 8'h0A);
    n_checks++;
    if (pkt_valid !== 1'b1 || buttons !== 3'b100 || dy !== 9'h00A || pos_y !== 10'd469) begin
      n_fail++;
      $display("FAIL b2b_second: valid %b btn %b dy %h pos_y %0d expected 1 100 00a 469",
               pkt_valid, buttons, dy, pos_y);
    end
  endtask

  task automatic test_rst_mid();
    send_byte(8'h0F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (pkt_valid !== 1'b0 || streaming !== 1'b0 || bus.rx_en !== 1'b0 ||
        buttons !== 3'b000 || dx !== 9'h000 || dy !== 9'h000) begin
      n_fail++;
      $display("FAIL rst_mid_flags: valid %b stream %b rx_en %b btn %b dx %h dy %h expected all 0",
               pkt_valid, streaming, bus.rx_en, buttons, dx, dy);
    end
    n_checks++;
    if (pos_x !== 10'd319 || pos_y !== 10'd239) begin
      n_fail++;
      $display("FAIL rst_mid_pos: got %0d,%0d expected 319,239", pos_x, pos_y);
    end
    send_byte(8'h05);
    send_byte(8'h7F);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n_checks++;
    if (pkt_valid !== 1'b0 || err_sync !== 1'b0 || bus.tx_trig !== 1'b0 ||
        streaming !== 1'b0 || pos_x !== 10'd319) begin
      n_fail++;
      $display("FAIL idle_ignores: valid %b err_sync %b trig %b stream %b pos_x %0d expected 0 0 0 0 319",
               pkt_valid, err_sync, bus.tx_trig, streaming, pos_x);
    end
  endtask

  task automatic test_retry();
    bit         seen;
    bit         trig_seen;
    logic [7:0] d;
    start = 1'b1;
    for (int r = 0; r < 4; r++) begin
      serve_cmd(seen, d);
      n_checks++;
      if (!seen || d !== FIRST_CMD) begin
        n_fail++;
        $display("FAIL retry_send%0d: seen %0d got %h expected %h", r, seen, d, FIRST_CMD);
      end
      send_byte(RSP_RESEND);
    end
    n_checks++;
    if (err_init !== 1'b1 || bus.tx_trig !== 1'b0 || bus.rx_en !== 1'b0 || streaming !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_exhausted: err_init %b trig %b rx_en %b stream %b expected 1 0 0 0",
               err_init, bus.tx_trig, bus.rx_en, streaming);
    end
    trig_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.tx_trig) trig_seen = 1'b1;
    end
    n_checks++;
    if (trig_seen !== 1'b0 || err_init !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_start_ignored: trig seen %b err_init %b expected 0 1", trig_seen, err_init);
    end
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (err_init !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_clear_by_rst: err_init %b expected 0", err_init);
    end
  endtask

  task automatic test_timeout();
    bit         seen;
    logic [7:0] d;
    int         cnt;
    start = 1'b1;
    serve_cmd(seen, d);
    n_checks++;
    if (!seen || d !== FIRST_CMD) begin
      n_fail++;
      $display("FAIL timeout_first: seen %0d got %h expected %h", seen, d, FIRST_CMD);
    end
    cnt = 0;
    for (int i = 1; i <= ACK_TO_TB + 10; i++) begin
      tick();
      if (bus.tx_trig) begin
        cnt = i;
        break;
      end
    end
    n_checks++;
    if (cnt !== ACK_TO_TB) begin
      n_fail++;
      $display("FAIL timeout_cycles: resend after %0d cycles expected %0d", cnt, ACK_TO_TB);
    end
    serve_cmd(seen, d);
    send_byte(RSP_ERR);
    serve_cmd(seen, d);
    n_checks++;
    if (!seen || d !== FIRST_CMD) begin
      n_fail++;
      $display("FAIL err_resend: seen %0d got %h expected %h", seen, d, FIRST_CMD);
    end
    send_byte(RSP_ACK);
    for (int k = 1; k < SEQ_N; k++) begin
      serve_cmd(seen, d);
      send_byte(RSP_ACK);
    end
    start = 1'b0;
    n_checks++;
    if (streaming !== 1'b1 || err_init !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_recover: streaming %b err_init %b expected 1 0", streaming, err_init);
    end
  endtask

`ifdef PS2_MOUSE_WHEEL_EN
  task automatic test_wheel();
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h0F);
    n_checks++;
    if (pkt_valid !== 1'b1 || dz !== 4'hF) begin
      n_fail++;
      $display("FAIL wheel_dz: valid %b dz %h expected 1 f", pkt_valid, dz);
    end
  endtask
`endif

  initial begin
    bus.tx_done  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_init();
    test_packet();
    test_resync();
    test_clamp_x_low();
    test_clamp_edges();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
    test_retry();
    test_timeout();
`ifdef PS2_MOUSE_WHEEL_EN
    test_wheel();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
